// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: round-robin arbiter sharing one AXI3 read slave, one burst at a time,
// with a sticky error flag when RLAST disagrees with the latched ARLEN.
module axi3_rd_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int GW = $clog2(N_MASTERS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_MASTERS-1:0]            m_arvalid,
   input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr,
   input  logic [N_MASTERS*4-1:0]          m_arlen,
   output logic [N_MASTERS-1:0]            m_arready,
   output logic [DATA_WIDTH-1:0]           m_rdata,
   output logic [N_MASTERS-1:0]            m_rvalid,
   output logic [N_MASTERS-1:0]            m_rlast,
   input  logic [N_MASTERS-1:0]            m_rready,
   output logic                            s_arvalid,
   output logic [ADDR_WIDTH-1:0]           s_araddr,
   output logic [3:0]                      s_arlen,
   input  logic                            s_arready,
   input  logic [DATA_WIDTH-1:0]           s_rdata,
   input  logic                            s_rvalid,
   input  logic                            s_rlast,
   output logic                            s_rready,
   output logic [GW-1:0]                   grant,
   output logic                            busy,
   output logic                            len_err
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
   state_e                  state_q, state_d;
   logic [GW-1:0]           grant_q, grant_d, rr_q, rr_d, win, sel;
   logic                    win_vld, beat;
   logic [3:0]              cnt_q, cnt_d, len_q, len_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   addr_a [N_MASTERS];
   logic [3:0]              len_a  [N_MASTERS];
   int                      idx;
   for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
      assign addr_a[g] = m_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_a[g]  = m_arlen[g*4 +: 4];
   end
   // Scan downward so the requester closest to rr_q (upward, wrapping) is the last to overwrite.
   always_comb begin
      win = '0;
      win_vld = 1'b0;
      idx = 0;
      sel = '0;
      for (int k = N_MASTERS-1; k >= 0; k--) begin
         idx = int'(rr_q) + k;
         if (idx >= N_MASTERS) idx -= N_MASTERS;
         sel = GW'(idx);
         if (m_arvalid[sel]) begin
            win = sel;
            win_vld = 1'b1;
         end
      end
   end
   assign beat = (state_q == DATA) && s_rvalid && s_rready;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d = rr_q;
      cnt_d = cnt_q;
      len_d = len_q;
      addr_d = addr_q;
      err_d = err_q;
      m_arready = '0;
      case (state_q)
         IDLE: if (win_vld && rst_n) begin
            m_arready[win] = 1'b1;
            state_d = ADDR;
            grant_d = win;
            addr_d = addr_a[win];
            len_d = len_a[win];
            cnt_d = '0;
         end
         ADDR: if (s_arready) state_d = DATA;
         DATA: if (beat) begin
            cnt_d = cnt_q + 4'd1;
            if (s_rlast) begin
               err_d = err_q | (cnt_q != len_q);
               rr_d = (grant_q == GW'(N_MASTERS-1)) ? '0 : grant_q + 1'b1;
               state_d = IDLE;
            end else begin
               err_d = err_q | (cnt_q == len_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      m_rvalid = '0;
      m_rlast = '0;
      m_rvalid[grant_q] = (state_q == DATA) && s_rvalid;
      m_rlast[grant_q] = (state_q == DATA) && s_rvalid && s_rlast;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
         addr_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q <= rr_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         addr_q <= addr_d;
         err_q <= err_d;
      end
   end
   assign s_arvalid = state_q == ADDR;
   assign s_araddr = addr_q;
   assign s_arlen = len_q;
   assign s_rready = (state_q == DATA) && m_rready[grant_q];
   assign m_rdata = s_rdata;
   assign grant = grant_q;
   assign busy = state_q != IDLE;
   assign len_err = err_q;
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: random masters and slave against a transaction-level reference model,
// including reset held with requests pending and resets cut into live bursts.
module tb_axi3_rd_arbiter;
   localparam int N = 2, AW = 32, DW = 32, GW = 1;
   logic clk = 1'b0, rst_n;
   logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
   logic [N*AW-1:0] m_araddr;
   logic [N*4-1:0] m_arlen;
   logic [DW-1:0] m_rdata, s_rdata;
   logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, busy, len_err;
   logic [AW-1:0] s_araddr;
   logic [3:0] s_arlen;
   logic [GW-1:0] grant;
   always #5 clk = ~clk;
   axi3_rd_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
      .grant(grant), .busy(busy), .len_err(len_err)
   );
   int n_tests = 0, n_fail = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   bit pend [N];
   logic [AW-1:0] req_addr [N];
   logic [3:0] req_len [N];
   int phase, gnt, rr, beats, w, n_rst;
   bit err;
   logic [AW-1:0] cur_addr;
   logic [3:0] cur_len;
   bit sl_on;
   logic [AW-1:0] sl_addr;
   int sl_last, sl_beat;
   function automatic int winner();
      for (int k = 0; k < N; k++) begin
         int j = (rr + k) % N;
         if (pend[j]) return j;
      end
      return -1;
   endfunction
   task automatic drive_masters();
      for (int i = 0; i < N; i++) begin
         m_arvalid[i] = pend[i];
         m_araddr[i*AW +: AW] = req_addr[i];
         m_arlen[i*4 +: 4] = req_len[i];
      end
   endtask
   task automatic model_reset();
      phase = 0; gnt = 0; rr = 0; beats = 0; err = 1'b0; sl_on = 1'b0;
   endtask
   initial begin
      model_reset();
      n_rst = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1;
         req_addr[i] = 32'h1000 * (i + 1);
         req_len[i] = 4'd7;
      end
      drive_masters();
      m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #4;
      check("rst_arready", m_arready, 0);
      check("rst_s_arvalid", s_arvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_len_err", len_err, 0);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         if (phase == 2 && beats == 2 && n_rst < 3 && $urandom_range(1) == 0) begin
            n_rst++;
            rst_n = 1'b0;
            #3;
            check("midrst_busy", busy, 0);
            check("midrst_arready", m_arready, 0);
            check("midrst_s_arvalid", s_arvalid, 0);
            check("midrst_s_rready", s_rready, 0);
            check("midrst_rvalid", m_rvalid, 0);
            check("midrst_grant", grant, 0);
            check("midrst_len_err", len_err, 0);
            model_reset();
            continue;
         end
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i] = 1'b1;
               req_addr[i] = $urandom & 32'hFFFF_FFFC;
               req_len[i] = ($urandom_range(5) == 0) ? 4'd0 : 4'($urandom_range(7));
            end
         drive_masters();
         m_rready = N'($urandom);
         s_arready = $urandom_range(2) != 0;
         if (sl_on) begin
            s_rvalid = $urandom_range(3) != 0;
            s_rdata = sl_addr + 32'(4 * sl_beat);
            s_rlast = sl_beat == sl_last;
         end else begin
            s_rvalid = 1'($urandom);
            s_rlast = 1'($urandom);
            s_rdata = $urandom;
         end
         #3;
         w = (phase == 0) ? winner() : -1;
         check("arready", m_arready, (w >= 0) ? (64'd1 << w) : 64'd0);
         check("busy", busy, phase != 0);
         check("grant", grant, gnt);
         check("s_arvalid", s_arvalid, phase == 1);
         if (phase == 1) begin
            check("s_araddr", s_araddr, cur_addr);
            check("s_arlen", s_arlen, cur_len);
         end
         check("s_rready", s_rready, (phase == 2) ? m_rready[gnt] : 1'b0);
         check("m_rvalid", m_rvalid, (phase == 2 && s_rvalid) ? (64'd1 << gnt) : 64'd0);
         check("m_rlast", m_rlast, (phase == 2 && s_rvalid && s_rlast) ? (64'd1 << gnt) : 64'd0);
         check("m_rdata", m_rdata, s_rdata);
         check("len_err", len_err, err);
         if (s_arvalid && s_arready) begin
            sl_on = 1'b1;
            sl_addr = s_araddr;
            sl_last = ($urandom_range(7) == 0) ? $urandom_range(15) : int'(s_arlen);
            sl_beat = 0;
         end else if (sl_on && s_rvalid && s_rready) begin
            if (s_rlast) sl_on = 1'b0;
            sl_beat++;
         end
         if (phase == 0 && w >= 0) begin
            phase = 1; gnt = w; pend[w] = 1'b0;
            cur_addr = req_addr[w]; cur_len = req_len[w]; beats = 0;
         end else if (phase == 1 && s_arready) begin
            phase = 2;
         end else if (phase == 2 && s_rvalid && m_rready[gnt]) begin
            if (s_rlast) begin
               err |= beats != int'(cur_len);
               phase = 0;
               rr = (gnt + 1) % N;
            end else begin
               err |= beats == int'(cur_len);
            end
            beats = (beats + 1) % 16;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
